// File: rtl/trap_controller_if.sv
// EXE-stage trap bus: instruction status into the trap unit, redirect and CSR state out of it.
// The trap unit always accepts its inputs and never stalls, so the bus carries no ready signal.
interface trap_controller_if #(
    parameter int PC_W = 15,
    parameter int XLEN = 64
);
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic [6:0]      OPCODE;
    logic            branch_taken;
    logic [PC_W-1:0] branch_address;
    logic [PC_W-1:0] mem_addr;
    logic [3:0]      MemRead_EXE;
    logic [3:0]      MemWrite_EXE;
    logic            sret;
    logic            exception;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            in_handler;
    logic            double_fault;
    logic [PC_W-1:0] sepc;
    logic [XLEN-1:0] scause;
    logic [XLEN-1:0] stval;

    modport master (
        output instr_valid, pc, OPCODE, branch_taken, branch_address, mem_addr,
               MemRead_EXE, MemWrite_EXE, sret,
        input  exception, redirect_valid, redirect_pc, in_handler, double_fault,
               sepc, scause, stval
    );

    modport slave (
        input  instr_valid, pc, OPCODE, branch_taken, branch_address, mem_addr,
               MemRead_EXE, MemWrite_EXE, sret,
        output exception, redirect_valid, redirect_pc, in_handler, double_fault,
               sepc, scause, stval
    );
endinterface

// File: rtl/trap_controller.sv
// Registered supervisor trap unit: prioritised cause detection, sepc/scause/stval capture, stvec/sepc redirect.
// Optional macro TRAP_STVAL_EN adds the stval register; without it stval is tied to zero.
module trap_controller #(
    parameter int              PC_W  = 15,
    parameter int              XLEN  = 64,
    parameter logic [PC_W-1:0] STVEC = 15'h0100
) (
    input  logic             clk,
    input  logic             rst,
    trap_controller_if.slave bus,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] sepc_q, sepc_d;
    logic [XLEN-1:0] scause_q, scause_d;
    logic            double_fault_q, double_fault_d;

    logic            hit;
    logic [2:0]      code;
    logic            rd_illegal, wr_illegal, op_illegal;

    function automatic logic be_illegal(input logic [3:0] c);
        return !(c == 4'b0000 || c == 4'b0001 || c == 4'b0011 || c == 4'b1111);
    endfunction

    function automatic logic be_misaligned(input logic [3:0] c, input logic [1:0] a);
        return (c == 4'b0011 && a[0]) || (c == 4'b1111 && a != 2'b00);
    endfunction

    always_comb begin
        op_illegal = 1'b1;
        case (bus.OPCODE)
            7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: op_illegal = 1'b0;
            default:                           op_illegal = 1'b1;
        endcase
    end

    assign rd_illegal = be_illegal(bus.MemRead_EXE);
    assign wr_illegal = be_illegal(bus.MemWrite_EXE);

    // Fixed priority: fetch misalign, illegal, load misalign, store misalign.
    always_comb begin
        hit  = 1'b0;
        code = 3'd0;
        if (bus.instr_valid) begin
            if (bus.branch_taken && bus.branch_address[1:0] != 2'b00) begin
                hit  = 1'b1;
                code = 3'd0;
            end else if (op_illegal || rd_illegal || wr_illegal ||
                         (bus.MemRead_EXE != 4'b0000 && bus.MemWrite_EXE != 4'b0000)) begin
                hit  = 1'b1;
                code = 3'd2;
            end else if (be_misaligned(bus.MemRead_EXE, bus.mem_addr[1:0])) begin
                hit  = 1'b1;
                code = 3'd4;
            end else if (be_misaligned(bus.MemWrite_EXE, bus.mem_addr[1:0])) begin
                hit  = 1'b1;
                code = 3'd6;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        sepc_d             = sepc_q;
        scause_d           = scause_q;
        double_fault_d     = double_fault_q;
        bus.exception      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.in_handler     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    sepc_d   = bus.pc;
                    scause_d = {{(XLEN-3){1'b0}}, code};
                    state_d  = TRAP;
                end
            end
            TRAP: begin
                bus.exception      = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = STVEC;
                state_d            = HANDLER;
            end
            HANDLER: begin
                bus.in_handler = 1'b1;
                if (bus.sret && bus.instr_valid) begin
                    state_d = RETURN;
                end else if (hit) begin
                    double_fault_d = 1'b1;
                end
            end
            RETURN: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = sepc_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sepc_q         <= '0;
            scause_q       <= '0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sepc_q         <= sepc_d;
            scause_q       <= scause_d;
            double_fault_q <= double_fault_d;
        end
    end

`ifdef TRAP_STVAL_EN
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] stval_q;

    always_comb begin
        tval = '0;
        case (code)
            3'd0:    tval = {{(XLEN-PC_W){1'b0}}, bus.branch_address};
            3'd2:    tval = {{(XLEN-7){1'b0}}, bus.OPCODE};
            default: tval = {{(XLEN-PC_W){1'b0}}, bus.mem_addr};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stval_q <= '0;
        end else if (state_q == IDLE && hit) begin
            stval_q <= tval;
        end
    end

    assign bus.stval = stval_q;
`else
    assign bus.stval = '0;
`endif

    assign bus.sepc         = sepc_q;
    assign bus.scause       = scause_q;
    assign bus.double_fault = double_fault_q;
    assign dbg_state_o      = state_q;

endmodule
